// File: rtl/pipe_controller.sv
// Pipelined RV32 control unit: combinational Decode, then Execute/Memory/Writeback
// control registers with an Execute-stage stall (bubble into Memory) and flush.
module pipe_controller #(
  parameter int unsigned ALUW = 4,
  parameter bit          EXT  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opD,
  input  logic [2:0]      funct3D,
  input  logic            funct7b5D,
  output logic [2:0]      ImmSrcD,
  output logic            IllegalD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ZeroE,
  input  logic            LtE,
  input  logic            LtuE,
  output logic            PCSrcE,
  output logic            PCTargetSrcE,
  output logic [ALUW-1:0] ALUControlE,
  output logic [1:0]      ALUSrcAE,
  output logic            ALUSrcBE,
  output logic            ResultSrcEb0,
  output logic            IllegalE,
  output logic            MemWriteM,
  output logic            RegWriteM,
  output logic [2:0]      Funct3M,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW
);
  typedef enum logic [6:0] {
    OP_BUBBLE = 7'b0000000,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_IALU   = 7'b0010011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } aluop_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} immsrc_e;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_e;
  typedef enum logic [1:0] {SRCA_RS1, SRCA_ZERO, SRCA_PC} srca_e;

  typedef struct packed {
    logic            regWrite;
    logic [1:0]      resultSrc;
    logic            memWrite;
    logic            jump;
    logic            branch;
    logic [2:0]      funct3;
    logic [ALUW-1:0] aluControl;
    logic [1:0]      aluSrcA;
    logic            aluSrcB;
    logic            pcTargetSrc;
    logic            illegal;
  } ctlE_t;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic [2:0] funct3;
  } ctlM_t;

  ctlE_t      ctlD, ctlE;
  ctlM_t      ctlM, ctlEtoM;
  logic [3:0] functAlu, branchAlu, aluD;
  logic       functExtOnly, illD, takenE;
  logic [2:0] immD;

  // Shared R/I funct decode; sub needs opD[5] so I-type never becomes sub.
  always_comb begin
    functAlu     = ALU_ADD;
    functExtOnly = 1'b0;
    case (funct3D)
      3'b000: functAlu = (opD[5] && funct7b5D) ? ALU_SUB : ALU_ADD;
      3'b001: begin functAlu = ALU_SLL;  functExtOnly = 1'b1; end
      3'b010: functAlu = ALU_SLT;
      3'b011: begin functAlu = ALU_SLTU; functExtOnly = 1'b1; end
      3'b100: functAlu = ALU_XOR;
      3'b101: begin functAlu = funct7b5D ? ALU_SRA : ALU_SRL; functExtOnly = 1'b1; end
      3'b110: functAlu = ALU_OR;
      default: functAlu = ALU_AND;
    endcase
  end

  always_comb begin
    case (funct3D[2:1])
      2'b10:   branchAlu = ALU_SLT;
      2'b11:   branchAlu = ALU_SLTU;
      default: branchAlu = ALU_SUB;
    endcase
  end

  always_comb begin
    ctlD        = '0;
    immD        = IMM_I;
    illD        = 1'b0;
    aluD        = ALU_ADD;
    ctlD.funct3 = funct3D;
    case (opD)
      OP_LOAD: begin
        ctlD.regWrite  = 1'b1;
        ctlD.aluSrcB   = 1'b1;
        ctlD.resultSrc = RES_MEM;
      end
      OP_STORE: begin
        immD          = IMM_S;
        ctlD.aluSrcB  = 1'b1;
        ctlD.memWrite = 1'b1;
      end
      OP_RTYPE: begin
        ctlD.regWrite = 1'b1;
        aluD          = functAlu;
        illD          = !EXT && functExtOnly;
      end
      OP_BRANCH: begin
        immD        = IMM_B;
        ctlD.branch = 1'b1;
        aluD        = branchAlu;
        illD        = (funct3D[2:1] == 2'b01) || (!EXT && funct3D != 3'b000);
      end
      OP_IALU: begin
        ctlD.regWrite = 1'b1;
        ctlD.aluSrcB  = 1'b1;
        aluD          = functAlu;
        illD          = !EXT && functExtOnly;
      end
      OP_JAL: begin
        immD           = IMM_J;
        ctlD.regWrite  = 1'b1;
        ctlD.jump      = 1'b1;
        ctlD.resultSrc = RES_PC4;
      end
      OP_JALR: begin
        ctlD.regWrite    = 1'b1;
        ctlD.aluSrcB     = 1'b1;
        ctlD.jump        = 1'b1;
        ctlD.pcTargetSrc = 1'b1;
        ctlD.resultSrc   = RES_PC4;
        illD             = !EXT || funct3D != 3'b000;
      end
      OP_LUI: begin
        immD          = IMM_U;
        ctlD.regWrite = 1'b1;
        ctlD.aluSrcA  = SRCA_ZERO;
        ctlD.aluSrcB  = 1'b1;
      end
      OP_AUIPC: begin
        immD          = IMM_U;
        ctlD.regWrite = 1'b1;
        ctlD.aluSrcA  = SRCA_PC;
        ctlD.aluSrcB  = 1'b1;
        illD          = !EXT;
      end
      OP_BUBBLE: ctlD.funct3 = '0;
      default:   illD = 1'b1;
    endcase
    ctlD.aluControl = ALUW'(aluD);
    if (illD) begin
      ctlD         = '0;
      ctlD.illegal = 1'b1;
      immD         = IMM_I;
    end
  end

  assign ImmSrcD  = immD;
  assign IllegalD = illD;
  assign ctlEtoM  = {ctlE.regWrite, ctlE.resultSrc, ctlE.memWrite, ctlE.funct3};

  // Flush outranks stall, so a flush still lets M take the old E entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctlE       <= '0;
      ctlM       <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      if (FlushE) begin
        ctlE <= '0;
        ctlM <= ctlEtoM;
      end else if (StallE) begin
        ctlM <= '0;
      end else begin
        ctlE <= ctlD;
        ctlM <= ctlEtoM;
      end
      RegWriteW  <= ctlM.regWrite;
      ResultSrcW <= ctlM.resultSrc;
    end
  end

  always_comb begin
    case (ctlE.funct3)
      3'b000:  takenE = ZeroE;
      3'b001:  takenE = !ZeroE;
      3'b100:  takenE = LtE;
      3'b101:  takenE = !LtE;
      3'b110:  takenE = LtuE;
      3'b111:  takenE = !LtuE;
      default: takenE = 1'b0;
    endcase
  end

  assign PCSrcE       = ctlE.jump | (ctlE.branch & takenE);
  assign PCTargetSrcE = ctlE.pcTargetSrc;
  assign ALUControlE  = ctlE.aluControl;
  assign ALUSrcAE     = ctlE.aluSrcA;
  assign ALUSrcBE     = ctlE.aluSrcB;
  assign ResultSrcEb0 = ctlE.resultSrc[0];
  assign IllegalE     = ctlE.illegal;
  assign MemWriteM    = ctlM.memWrite;
  assign RegWriteM    = ctlM.regWrite;
  assign Funct3M      = ctlM.funct3;
endmodule

// File: doc/pipe_controller.md
# pipe_controller

Parametrised pipelined control unit for the RV32 core: decodes opcode/funct fields in Decode and carries control through Execute, Memory and Writeback pipeline registers, with stall and flush support. Extends the base controller with the full conditional-branch set, `jalr`, `auipc` and shifts (mode `EXT`), a parametrised ALU-control width, an Execute-stage stall that injects bubbles into Memory, and an explicit illegal-instruction flag in place of X-propagation. It sits beside the datapath and feeds the hazard unit.

## Interface
- `ALUW`, default 4: ALU control width. Must be ≥4 when `EXT=1` and ≥3 when `EXT=0`. Codes are zero-extended to `ALUW`.
- `EXT`, default 1: 1 enables `bne/blt/bge/bltu/bgeu`, `jalr`, `auipc`, `sltu`/`sltiu` and shifts. 0 limits the unit to the base set (`lw, sw, R/I add/sub/and/or/xor/slt, beq, jal, lui`).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high. Clears every pipeline register.
- `opD` in 7, `funct3D` in 3, `funct7b5D` in 1: instruction fields.
- `ImmSrcD` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `IllegalD` out 1: unimplemented encoding in Decode.
- `StallE` in 1: hold the E register and insert a bubble into M.
- `FlushE` in 1: clear the E register. Takes priority over `StallE`.
- `ZeroE`, `LtE`, `LtuE` in 1 each: ALU flags (zero, signed less, unsigned less).
- `PCSrcE` out 1: take branch/jump.
- `PCTargetSrcE` out 1: 0 = PC+imm, 1 = ALU result (`jalr`).
- `ALUControlE` out `ALUW`.
- `ALUSrcAE` out 2: 00 rs1, 01 zero, 10 PC.
- `ALUSrcBE` out 1: 0 rs2, 1 imm.
- `ResultSrcEb0` out 1: for the hazard unit.
- `IllegalE` out 1.
- `MemWriteM` out 1, `RegWriteM` out 1, `Funct3M` out 3: load/store size.
- `RegWriteW` out 1, `ResultSrcW` out 2: 00 ALU, 01 memory, 10 PC+4.

## Operation
- **Decode is combinational.** Opcodes:
  - `lw` 0000011: RegWrite, I, B=imm, Result=01, add.
  - `sw` 0100011: S, B=imm, MemWrite, add.
  - R-type 0110011: RegWrite, ALUOp=funct.
  - B-type 1100011: B, Branch, sub / slt / sltu per funct3.
  - I-ALU 0010011: RegWrite, I, B=imm, ALUOp=funct.
  - `jal` 1101111: RegWrite, J, Jump, Result=10.
  - `jalr` 1100111: RegWrite, I, B=imm, Jump, PCTargetSrc=1, Result=10, add.
  - `lui` 0110111: RegWrite, U, A=zero, B=imm, add.
  - `auipc` 0010111: RegWrite, U, A=PC, B=imm, add.
  - 0000000: all controls 0, IllegalD=0 (reset-safe bubble).
- **ALU codes:** 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- **Funct decoding:**
  - sub only when `opD[5]`=1 and `funct7b5D`=1 with funct3=000.
  - funct3=101 selects sra when `funct7b5D`=1, else srl, for both R and I.
  - funct3 001 → sll; 011 → sltu.
- **Illegal encodings** force all controls and `ImmSrcD` to 0 and set `IllegalD`=1. No X is ever output. Illegal encodings are:
  - any other opcode;
  - branch funct3 010/011;
  - `jalr` funct3≠000;
  - when `EXT=0`: `jalr`, `auipc`, branch funct3≠000, and ALU funct3 001/011/101.
- **Branch condition in E** (using registered `Funct3E`): 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu. `PCSrcE = JumpE | (BranchE & cond)`. Branch ALU op: sub for beq/bne, slt for blt/bge, sltu for bltu/bgeu.
- **E register** holds RegWrite, ResultSrc, MemWrite, Jump, Branch, Funct3, ALUControl, ALUSrcA, ALUSrcB, PCTargetSrc, Illegal.
- **M register** holds RegWrite, ResultSrc, MemWrite, Funct3.
- **W register** holds RegWrite, ResultSrc.
- **Edge behaviour, by priority:**
  - `FlushE`: E ← 0.
  - else `StallE`: E holds and M ← 0.
  - else: E ← D and M ← E.
- W always loads M.

## Timing
- Decode outputs are combinational from `opD`/`funct3D`/`funct7b5D`. Latency D→E is 1 edge, E→M 1, M→W 1.
- `PCSrcE`/`PCTargetSrcE` are combinational from E registers and flags in the same cycle.
- **Reset** (asynchronous, immediate): every registered output is 0, so `PCSrcE`=0 and `ALUControlE`=0. Reset mid-stream discards all in-flight control.
- `FlushE` and `StallE` both high: flush wins, and M still loads E (no bubble injected by stall).
- A flushed or illegal E entry has RegWrite/MemWrite/Branch/Jump=0, so it never writes or redirects. `IllegalE`=1 only for an unflushed illegal entry.
- A stall held for N cycles keeps E constant and emits N bubbles into M. W drains normally.

## Test plan
- **Reset:** assert `reset` mid-cycle with a `sw` in M → `MemWriteM`=0 immediately. After release with `opD`=0, all outputs are 0.
- **Instruction sweep:** each opcode/funct combination with `EXT=1`, `ALUW=4` → `ImmSrcD`/`ALUControlE` as tabled. For example, I-type funct3=101, `funct7b5D`=1 → `ALUControlE`=1001 one edge later.
- **Branch conditions:** bge with `LtE`=0 → `PCSrcE`=1; with `LtE`=1 → 0. bne with `ZeroE`=1 → 0. `jalr` → `PCSrcE`=1 and `PCTargetSrcE`=1.
- **Pipeline flow:** `lw` → `RegWriteW`=1 and `ResultSrcW`=01 exactly 3 edges after Decode.
- **Stall/flush:** `sw` in E with `StallE`=1 for 2 cycles → `MemWriteM`=0 for those 2 cycles, then 1. `FlushE`+`StallE` together → E cleared and M loads the previous E.
- **Mode EXT=0, ALUW=3:** `opD`=1100111 → `IllegalD`=1 and all controls 0. beq still works. `IllegalE`=1 one edge later with `PCSrcE`=0.
